// File: rtl/pokey_serout.sv
// POKEY serial output: SEROUT holding register feeding a 10-bit start/data/stop frame shifter.
// Define POKEY_SEROUT_BREAK_EN to add the force_break input, which holds sod low while asserted.
module pokey_serout (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enp,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       baud_tick,
`ifdef POKEY_SEROUT_BREAK_EN
    input  logic       force_break,
`endif
    output logic       sod,
    output logic       need_irq,
    output logic       done,
    output logic       busy
);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [9:0]  sh_q, sh_d;
    logic [3:0]  idx_q, idx_d;
    logic        frame_q, frame_d;
    logic        need_irq_q, need_irq_d;
    logic        load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        need_irq_d  = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enp && hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (enp && baud_tick) begin
                    if (idx_q != 4'd9) begin
                        idx_d   = idx_q + 4'd1;
                        frame_d = sh_q[idx_q + 4'd1];
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        frame_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The transfer consumes the old hold; a same-clk write still leaves hold_full set.
        if (load) begin
            sh_d        = {1'b1, hold_q, 1'b0};
            idx_d       = 4'd0;
            frame_d     = 1'b0;
            need_irq_d  = 1'b1;
            state_d     = S_SHIFT;
            hold_full_d = 1'b0;
        end

        if (wr_en) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '1;
            idx_q       <= '0;
            frame_q     <= 1'b1;
            need_irq_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            need_irq_q  <= need_irq_d;
        end
    end

`ifdef POKEY_SEROUT_BREAK_EN
    logic sod_q, sod_d;

    always_comb begin
        sod_d = frame_d & ~force_break;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sod_q <= 1'b1;
        end else begin
            sod_q <= sod_d;
        end
    end

    assign sod = sod_q;
`else
    assign sod = frame_q;
`endif

    assign need_irq = need_irq_q;
    assign busy     = (state_q == S_SHIFT);
    assign done     = (state_q == S_IDLE) && !hold_full_q;

endmodule

// File: tb/tb_pokey_serout.sv
// Directed, table-driven bench for pokey_serout with hand-computed frame expectations.
module tb_pokey_serout;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enp = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] din = '0;
    logic       baud_tick = 1'b0;
`ifdef POKEY_SEROUT_BREAK_EN
    logic       force_break = 1'b0;
`endif
    logic       sod, need_irq, done, busy;

    int errors = 0;
    int checks = 0;

    pokey_serout dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enp       (enp),
        .wr_en     (wr_en),
        .din       (din),
        .baud_tick (baud_tick),
`ifdef POKEY_SEROUT_BREAK_EN
        .force_break(force_break),
`endif
        .sod       (sod),
        .need_irq  (need_irq),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       w;
        logic [7:0] d;
        logic       t;
        logic       x_sod;
        logic       x_need;
        logic       x_done;
        logic       x_busy;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one clk worth of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic e, input logic w, input logic [7:0] d, input logic t);
        enp = e; wr_en = w; din = d; baud_tick = t;
        @(posedge clk);
        #1;
        wr_en = 1'b0; baud_tick = 1'b0;
    endtask

    task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input int gap, input bit b_at_load);
        logic [9:0] fa, fb;
        logic       expv, prev;
        fa = {1'b1, a, 1'b0};
        fb = {1'b1, b, 1'b0};
        if (b_at_load) begin
            cyc(1'b0, 1'b1, a, 1'b0);
            chk("pair pre-load done", done, 0);
            cyc(1'b1, 1'b1, b, 1'b0);
        end else begin
            cyc(1'b1, 1'b1, a, 1'b0);
            chk("pair pre-load done", done, 0);
            chk("pair pre-load sod", sod, 1);
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
        end
        chk("pair load need", need_irq, 1);
        chk("pair load sod", sod, 0);
        chk("pair load busy", busy, 1);
        prev = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            for (int g = 1; g < gap; g++) begin
                cyc(1'b1, (!b_at_load && t == 5 && g == 1), b, 1'b0);
                chk($sformatf("pair t%0d g%0d sod", t, g), sod, prev);
                chk($sformatf("pair t%0d g%0d need", t, g), need_irq, 0);
                chk($sformatf("pair t%0d g%0d busy", t, g), busy, 1);
            end
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            if (t <= 9)       expv = fa[t];
            else if (t <= 19) expv = fb[t-10];
            else              expv = 1'b1;
            chk($sformatf("pair tick%0d sod", t), sod, expv);
            chk($sformatf("pair tick%0d need", t), need_irq, (t == 10));
            chk($sformatf("pair tick%0d busy", t), busy, (t < 20));
            chk($sformatf("pair tick%0d done", t), done, (t == 20));
            prev = expv;
        end
    endtask

    initial begin
        //          e  w  d      t  sod need done busy
        vecs[0]  = '{1, 0, 8'h00, 1, 1, 0, 1, 0};
        vecs[1]  = '{0, 1, 8'hA5, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 0, 8'h00, 0, 0, 1, 0, 1};
        vecs[4]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1};
        vecs[6]  = '{1, 0, 8'h00, 1, 1, 0, 0, 1};
        vecs[7]  = '{1, 0, 8'h00, 1, 0, 0, 0, 1};
        vecs[8]  = '{1, 0, 8'h00, 1, 1, 0, 0, 1};
        vecs[9]  = '{1, 0, 8'h00, 1, 0, 0, 0, 1};
        vecs[10] = '{1, 0, 8'h00, 1, 0, 0, 0, 1};
        vecs[11] = '{1, 0, 8'h00, 1, 1, 0, 0, 1};
        vecs[12] = '{1, 0, 8'h00, 1, 0, 0, 0, 1};
        vecs[13] = '{1, 0, 8'h00, 1, 1, 0, 0, 1};
        vecs[14] = '{1, 0, 8'h00, 1, 1, 0, 0, 1};
        vecs[15] = '{1, 0, 8'h00, 0, 1, 0, 0, 1};
        vecs[16] = '{1, 0, 8'h00, 1, 1, 0, 1, 0};

        // Reset held for 3 clk, then idle with enp high.
        repeat (3) @(posedge clk);
        #1;
        chk("reset sod", sod, 1);
        chk("reset need", need_irq, 0);
        chk("reset done", done, 1);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0);
            chk($sformatf("idle%0d sod", i), sod, 1);
            chk($sformatf("idle%0d need", i), need_irq, 0);
            chk($sformatf("idle%0d done", i), done, 1);
            chk($sformatf("idle%0d busy", i), busy, 0);
        end

        // Single 0xA5 frame, including enp gating of load and ticks.
        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].e, vecs[i].w, vecs[i].d, vecs[i].t);
            chk($sformatf("vec%0d sod", i), sod, vecs[i].x_sod);
            chk($sformatf("vec%0d need", i), need_irq, vecs[i].x_need);
            chk($sformatf("vec%0d done", i), done, vecs[i].x_done);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].x_busy);
        end

        // Back-to-back frames, tick every 4th clk, second byte written mid-frame.
        run_pair(8'h0F, 8'hF0, 4, 1'b0);
        // Write coinciding with transfer, tick every clk.
        run_pair(8'h55, 8'h33, 1, 1'b1);

        // Reset mid-frame at idx=4 with a byte pending.
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 8'h77, 1'b0);
        chk("midrst pre sod", sod, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst async sod", sod, 1);
        chk("midrst async busy", busy, 0);
        chk("midrst async done", done, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            chk($sformatf("postrst%0d sod", i), sod, 1);
            chk($sformatf("postrst%0d need", i), need_irq, 0);
            chk($sformatf("postrst%0d done", i), done, 1);
            chk($sformatf("postrst%0d busy", i), busy, 0);
        end

`ifdef POKEY_SEROUT_BREAK_EN
        // Break during a 0xFF frame: sod low only while forced, frame timing unchanged.
        cyc(1'b1, 1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("brk load need", need_irq, 1);
        chk("brk load sod", sod, 0);
        for (int t = 1; t <= 10; t++) begin
            force_break = (t >= 3 && t <= 5);
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            chk($sformatf("brk tick%0d sod", t), sod, (t >= 3 && t <= 5) ? 0 : 1);
            chk($sformatf("brk tick%0d need", t), need_irq, 0);
            chk($sformatf("brk tick%0d busy", t), busy, (t < 10));
            chk($sformatf("brk tick%0d done", t), done, (t == 10));
        end
        force_break = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
